// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and memory-side signals around the shared memory port.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_gnt;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_gnt;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wr_en;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rd_data,
        output wr_gnt, rd_gnt, rd_valid, rd_data, mem_addr, mem_wr_en, mem_wr_data
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_rd_data,
        input  wr_gnt, rd_gnt, rd_valid, rd_data, mem_addr, mem_wr_en, mem_wr_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Weighted round-robin arbiter sharing one single-port synchronous memory between a
// write requester and a read requester, with a registered read-return pipeline.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WR_WEIGHT  = 2,
    parameter int unsigned RD_WEIGHT  = 2
) (
    input logic                CLK,
    input logic                RST,
    mem_port_arbiter_if.slave  bus
);
    localparam int unsigned MAX_WEIGHT = (WR_WEIGHT > RD_WEIGHT) ? WR_WEIGHT : RD_WEIGHT;
    localparam int unsigned CREDIT_W   = $clog2(MAX_WEIGHT) + 1;

    localparam logic [CREDIT_W-1:0] WR_CREDIT    = CREDIT_W'(WR_WEIGHT);
    localparam logic [CREDIT_W-1:0] RD_CREDIT    = CREDIT_W'(RD_WEIGHT);
    localparam logic [CREDIT_W-1:0] WR_CREDIT_M1 = CREDIT_W'(WR_WEIGHT - 1);
    localparam logic [CREDIT_W-1:0] RD_CREDIT_M1 = CREDIT_W'(RD_WEIGHT - 1);

    typedef enum logic {OwnWr, OwnRd} owner_e;

    owner_e                owner_q, owner_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [CREDIT_W-1:0]   credit_dec;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  wr_gnt, rd_gnt;

    // Under contention the owner wins while it still has credit, else the other side.
    always_comb begin
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (!RST) begin
            if (bus.wr_req && bus.rd_req) begin
                if ((owner_q == OwnWr) == (credit_q != '0)) begin
                    wr_gnt = 1'b1;
                end else begin
                    rd_gnt = 1'b1;
                end
            end else begin
                wr_gnt = bus.wr_req;
                rd_gnt = bus.rd_req;
            end
        end
    end

    assign credit_dec = credit_q - CREDIT_W'(1);

    always_comb begin
        owner_d  = owner_q;
        credit_d = credit_q;
        if (wr_gnt) begin
            if (owner_q == OwnWr) begin
                if (bus.rd_req) begin
                    if (credit_dec == '0) begin
                        owner_d  = OwnRd;
                        credit_d = RD_CREDIT;
                    end else begin
                        credit_d = credit_dec;
                    end
                end else begin
                    credit_d = WR_CREDIT;
                end
            end else if (WR_CREDIT_M1 == '0 && bus.rd_req) begin
                owner_d  = OwnRd;
                credit_d = RD_CREDIT;
            end else begin
                owner_d  = OwnWr;
                credit_d = WR_CREDIT_M1;
            end
        end else if (rd_gnt) begin
            if (owner_q == OwnRd) begin
                if (bus.wr_req) begin
                    if (credit_dec == '0) begin
                        owner_d  = OwnWr;
                        credit_d = WR_CREDIT;
                    end else begin
                        credit_d = credit_dec;
                    end
                end else begin
                    credit_d = RD_CREDIT;
                end
            end else if (RD_CREDIT_M1 == '0 && bus.wr_req) begin
                owner_d  = OwnWr;
                credit_d = WR_CREDIT;
            end else begin
                owner_d  = OwnRd;
                credit_d = RD_CREDIT_M1;
            end
        end
    end

    // mem_rd_data is valid the cycle after rd_gnt; capture it on the following edge.
    always_comb begin
        rd_pend_d  = rd_gnt;
        rd_valid_d = rd_pend_q;
        rd_data_d  = rd_pend_q ? bus.mem_rd_data : rd_data_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            owner_q    <= OwnWr;
            credit_q   <= WR_CREDIT;
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            owner_q    <= owner_d;
            credit_q   <= credit_d;
            rd_pend_q  <= rd_pend_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign bus.wr_gnt      = wr_gnt;
    assign bus.rd_gnt      = rd_gnt;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.mem_wr_en   = wr_gnt;
    assign bus.mem_wr_data = wr_gnt ? bus.wr_data : '0;
    assign bus.mem_addr    = wr_gnt ? bus.wr_addr : (rd_gnt ? bus.rd_addr : '0);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: two instances (weights 2:2 and 3:1), each
// backed by a behavioural single-port memory with a 1-cycle registered read.
module tb_mem_port_arbiter;
    logic CLK;
    logic RST;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus_a ();
    mem_port_arbiter_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus_b ();

    mem_port_arbiter #(
        .ADDR_WIDTH(6), .DATA_WIDTH(32), .WR_WEIGHT(2), .RD_WEIGHT(2)
    ) u_dut_a (
        .CLK(CLK),
        .RST(RST),
        .bus(bus_a)
    );

    mem_port_arbiter #(
        .ADDR_WIDTH(6), .DATA_WIDTH(32), .WR_WEIGHT(3), .RD_WEIGHT(1)
    ) u_dut_b (
        .CLK(CLK),
        .RST(RST),
        .bus(bus_b)
    );

    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];

    always @(posedge CLK) begin
        if (bus_a.mem_wr_en) mem_a[bus_a.mem_addr] <= bus_a.mem_wr_data;
        bus_a.mem_rd_data <= mem_a[bus_a.mem_addr];
        if (bus_b.mem_wr_en) mem_b[bus_b.mem_addr] <= bus_b.mem_wr_data;
        bus_b.mem_rd_data <= mem_b[bus_b.mem_addr];
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        n_checks++;
        if (obs !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expected);
        end
    endtask

    // Inputs change just after the active edge; checks happen on the falling edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus_a.wr_req = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
        bus_a.rd_req = 1'b0; bus_a.rd_addr = '0;
        bus_b.wr_req = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
        bus_b.rd_req = 1'b0; bus_b.rd_addr = '0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    logic        w_seen, r_seen;
    logic [31:0] b_cap [$];

    initial begin
        idle_inputs();
        // Reset with requests asserted: grants and memory drive must stay quiet.
        RST = 1'b1;
        bus_a.wr_req = 1'b1; bus_a.wr_addr = 6'd9; bus_a.wr_data = 32'h1234;
        bus_a.rd_req = 1'b1; bus_a.rd_addr = 6'd9;
        @(negedge CLK);
        check_eq("rst_wr_gnt", {31'b0, bus_a.wr_gnt}, 32'd0);
        check_eq("rst_rd_gnt", {31'b0, bus_a.rd_gnt}, 32'd0);
        check_eq("rst_mem_wr_en", {31'b0, bus_a.mem_wr_en}, 32'd0);
        check_eq("rst_mem_addr", {26'b0, bus_a.mem_addr}, 32'd0);
        tick();
        tick();
        RST = 1'b0;
        idle_inputs();
        @(negedge CLK);
        check_eq("rst_rd_valid", {31'b0, bus_a.rd_valid}, 32'd0);
        check_eq("rst_rd_data", bus_a.rd_data, 32'd0);
        check_eq("idle_mem_wr_data", bus_a.mem_wr_data, 32'd0);
        tick();

        // Single write then read-back of the same address.
        bus_a.wr_req = 1'b1; bus_a.wr_addr = 6'd5; bus_a.wr_data = 32'hDEADBEEF;
        @(negedge CLK);
        check_eq("t1_wr_gnt", {31'b0, bus_a.wr_gnt}, 32'd1);
        check_eq("t1_mem_wr_en", {31'b0, bus_a.mem_wr_en}, 32'd1);
        check_eq("t1_mem_addr", {26'b0, bus_a.mem_addr}, 32'd5);
        check_eq("t1_mem_wr_data", bus_a.mem_wr_data, 32'hDEADBEEF);
        tick();
        bus_a.wr_req = 1'b0;
        bus_a.rd_req = 1'b1; bus_a.rd_addr = 6'd5;
        @(negedge CLK);
        check_eq("t1_rd_gnt", {31'b0, bus_a.rd_gnt}, 32'd1);
        check_eq("t1_rd_mem_wr_en", {31'b0, bus_a.mem_wr_en}, 32'd0);
        check_eq("t1_rd_mem_addr", {26'b0, bus_a.mem_addr}, 32'd5);
        tick();
        bus_a.rd_req = 1'b0;
        @(negedge CLK);
        check_eq("t1_rd_valid_c1", {31'b0, bus_a.rd_valid}, 32'd0);
        tick();
        @(negedge CLK);
        check_eq("t1_rd_valid_c2", {31'b0, bus_a.rd_valid}, 32'd1);
        check_eq("t1_rd_data", bus_a.rd_data, 32'hDEADBEEF);
        tick();
        @(negedge CLK);
        check_eq("t1_rd_valid_c3", {31'b0, bus_a.rd_valid}, 32'd0);
        check_eq("t1_rd_data_hold", bus_a.rd_data, 32'hDEADBEEF);

        // Contention on the 2:2 instance: W,W,R,R repeating from reset.
        do_reset();
        bus_a.wr_req = 1'b1; bus_a.wr_addr = 6'd40; bus_a.wr_data = 32'h55;
        bus_a.rd_req = 1'b1; bus_a.rd_addr = 6'd41;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            check_eq($sformatf("t2_wr_gnt[%0d]", i), {31'b0, bus_a.wr_gnt},
                     ((i / 2) % 2 == 0) ? 32'd1 : 32'd0);
            check_eq($sformatf("t2_rd_gnt[%0d]", i), {31'b0, bus_a.rd_gnt},
                     ((i / 2) % 2 == 1) ? 32'd1 : 32'd0);
            tick();
        end
        idle_inputs();

        // 3:1 instance: prefill addr 0..3 with 0xB0+n, then contend.
        do_reset();
        for (int n = 0; n < 4; n++) begin
            bus_b.wr_req = 1'b1; bus_b.wr_addr = 6'(n); bus_b.wr_data = 32'hB0 + 32'(n);
            @(negedge CLK);
            check_eq($sformatf("t3_fill_gnt[%0d]", n), {31'b0, bus_b.wr_gnt}, 32'd1);
            tick();
        end
        bus_b.wr_addr = 6'd16; bus_b.wr_data = 32'hA0;
        bus_b.rd_req = 1'b1; bus_b.rd_addr = 6'd0;
        for (int i = 0; i < 21; i++) begin
            if (i == 16) begin
                bus_b.wr_req = 1'b0;
                bus_b.rd_req = 1'b0;
            end
            @(negedge CLK);
            w_seen = bus_b.wr_gnt;
            r_seen = bus_b.rd_gnt;
            if (bus_b.rd_valid) b_cap.push_back(bus_b.rd_data);
            if (i < 16) begin
                check_eq($sformatf("t3_wr_gnt[%0d]", i), {31'b0, w_seen},
                         (i % 4 != 3) ? 32'd1 : 32'd0);
                check_eq($sformatf("t3_rd_gnt[%0d]", i), {31'b0, r_seen},
                         (i % 4 == 3) ? 32'd1 : 32'd0);
            end
            tick();
            if (w_seen) begin
                bus_b.wr_addr = bus_b.wr_addr + 6'd1;
                bus_b.wr_data = bus_b.wr_data + 32'd1;
            end
            if (r_seen) bus_b.rd_addr = bus_b.rd_addr + 6'd1;
        end
        check_eq("t3_rd_count", 32'(b_cap.size()), 32'd4);
        for (int n = 0; n < 4; n++) begin
            if (n < b_cap.size())
                check_eq($sformatf("t3_rd_data[%0d]", n), b_cap[n], 32'hB0 + 32'(n));
        end
        idle_inputs();

        // Pre-write addr*3 to 0..7, then a streamed read of 0..7.
        for (int n = 0; n < 8; n++) begin
            bus_a.wr_req = 1'b1; bus_a.wr_addr = 6'(n); bus_a.wr_data = 32'(n * 3);
            @(negedge CLK);
            check_eq($sformatf("t4_fill_gnt[%0d]", n), {31'b0, bus_a.wr_gnt}, 32'd1);
            tick();
        end
        bus_a.wr_req = 1'b0;
        for (int k = 0; k < 11; k++) begin
            bus_a.rd_req  = (k < 8);
            bus_a.rd_addr = 6'(k);
            @(negedge CLK);
            check_eq($sformatf("t4_rd_gnt[%0d]", k), {31'b0, bus_a.rd_gnt},
                     (k < 8) ? 32'd1 : 32'd0);
            check_eq($sformatf("t4_rd_valid[%0d]", k), {31'b0, bus_a.rd_valid},
                     (k >= 2 && k < 10) ? 32'd1 : 32'd0);
            if (k >= 2 && k < 10)
                check_eq($sformatf("t4_rd_data[%0d]", k), bus_a.rd_data, 32'((k - 2) * 3));
            tick();
        end
        idle_inputs();

        // Read addr 2, then overwrite it the next cycle; the read keeps the old value.
        bus_a.rd_req = 1'b1; bus_a.rd_addr = 6'd2;
        @(negedge CLK);
        check_eq("t5_rd_gnt0", {31'b0, bus_a.rd_gnt}, 32'd1);
        tick();
        bus_a.rd_req = 1'b0;
        bus_a.wr_req = 1'b1; bus_a.wr_addr = 6'd2; bus_a.wr_data = 32'h1;
        @(negedge CLK);
        check_eq("t5_wr_gnt", {31'b0, bus_a.wr_gnt}, 32'd1);
        tick();
        bus_a.wr_req = 1'b0;
        bus_a.rd_req = 1'b1; bus_a.rd_addr = 6'd2;
        @(negedge CLK);
        check_eq("t5_old_valid", {31'b0, bus_a.rd_valid}, 32'd1);
        check_eq("t5_old_data", bus_a.rd_data, 32'd6);
        check_eq("t5_rd_gnt1", {31'b0, bus_a.rd_gnt}, 32'd1);
        tick();
        bus_a.rd_req = 1'b0;
        tick();
        @(negedge CLK);
        check_eq("t5_new_valid", {31'b0, bus_a.rd_valid}, 32'd1);
        check_eq("t5_new_data", bus_a.rd_data, 32'h1);
        tick();

        // Reset the cycle after a read grant: the in-flight read is dropped.
        bus_a.rd_req = 1'b1; bus_a.rd_addr = 6'd7;
        @(negedge CLK);
        check_eq("t6_rd_gnt", {31'b0, bus_a.rd_gnt}, 32'd1);
        tick();
        bus_a.rd_req = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check_eq($sformatf("t6_rd_valid[%0d]", k), {31'b0, bus_a.rd_valid}, 32'd0);
            check_eq($sformatf("t6_rd_data[%0d]", k), bus_a.rd_data, 32'd0);
            tick();
        end
        bus_a.wr_req = 1'b1; bus_a.wr_addr = 6'd50; bus_a.wr_data = 32'h77;
        bus_a.rd_req = 1'b1; bus_a.rd_addr = 6'd51;
        @(negedge CLK);
        check_eq("t6_first_wr_gnt", {31'b0, bus_a.wr_gnt}, 32'd1);
        check_eq("t6_first_rd_gnt", {31'b0, bus_a.rd_gnt}, 32'd0);
        tick();
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
